// File: rtl/if_stage_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// if_stage_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ------------------------------------------------------------------
package if_stage_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  localparam logic [0:0] IF_RUN   = 1'b0;
  localparam logic [0:0] IF_DRAIN = 1'b1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return pc & ~64'h3;
  endfunction

  // Wraps silently at the top of the address space.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// if_stage_fifo : synchronous {pc,inst} buffer with push/pop/flush
// Rev 1.0
// ------------------------------------------------------------------
module if_stage_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// if_stage : instruction fetch - PC, imem requests, response buffer
// Rev 1.0
// ------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [0:0]    state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW:0]   credit_used;
  logic [CW:0]   stale;
  logic          req_ok, req_fire;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_rdata;

  if_stage_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    req_ok      = (state_q == IF_RUN) && !redirect_valid && (credit_used < DEPTH_W);
    req_fire    = req_ok && imem_req_ready;
    // A response retires an outstanding fetch in RUN or a pending drop in DRAIN,
    // so one sum covers both states (outstanding is always 0 in DRAIN).
    stale = {1'b0, drop_cnt_q} + {1'b0, outstanding_q}
          + (CW+1)'(req_fire) - (CW+1)'(imem_resp_valid);

    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    resp_pc_d       = resp_pc_q;
    outstanding_d   = outstanding_q;
    drop_cnt_d      = drop_cnt_q;
    fifo_push       = 1'b0;
    fifo_flush      = redirect_valid;
    fifo_pop        = inst_valid & inst_ready;
    fifo_wdata.pc   = resp_pc_q;
    fifo_wdata.inst = imem_resp_data;

    if (redirect_valid) begin
      fetch_pc_d    = pc_align(redirect_pc);
      resp_pc_d     = pc_align(redirect_pc);
      outstanding_d = '0;
      drop_cnt_d    = stale[CW-1:0];
      state_d       = (stale == '0) ? IF_RUN : IF_DRAIN;
    end else if (state_q == IF_RUN) begin
      if (req_fire) begin
        fetch_pc_d = pc_next(fetch_pc_q);
      end
      if (imem_resp_valid) begin
        fifo_push = 1'b1;
        resp_pc_d = pc_next(resp_pc_q);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    end else if (imem_resp_valid) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
      if (drop_cnt_q == CW'(1)) begin
        state_d = IF_RUN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IF_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // The credit rule keeps the buffer from ever being pushed while full without a pop.
  assert property (@(posedge clock) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop));

  assign imem_req_valid = req_ok & ~reset;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = ~fifo_empty;
  assign inst           = fifo_rdata.inst;
  assign inst_pc        = fifo_rdata.pc;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// tb_if_stage : directed scenarios plus randomized traffic against an
// address-sequence reference model and an in-order memory model.
module tb_if_stage;

  localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc     = 0;
  int    lat_min = 1;
  int    lat_max = 1;

  bit          ev_req, ev_acc, ev_iv, ev_del, ev_resp;
  logic [63:0] ev_addr, ev_pc;
  logic [31:0] ev_inst;

  always #5 clock = ~clock;

  if_stage #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock of the environment: memory answers in order, DUT outputs are
  // captured mid-cycle, memory bookkeeping is updated after the edge.
  task automatic cycle(input bit redir, input logic [63:0] rpc);
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    ev_req  = imem_req_valid;
    ev_addr = imem_req_addr;
    ev_acc  = imem_req_valid & imem_req_ready;
    ev_iv   = inst_valid;
    ev_del  = inst_valid & inst_ready;
    ev_pc   = inst_pc;
    ev_inst = inst;
    ev_resp = imem_resp_valid;
    @(posedge clock);
    #1;
    cyc++;
    if (ev_resp) void'(mq.pop_front());
    if (ev_acc) mq.push_back('{addr: ev_addr, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    mq.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b1;
    mq.delete();
    #2;
    vectors++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    vectors++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
    vectors++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      errors++; $display("FAIL rst_first_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RPC);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_req, exp_del;
    int n_del, first_del;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    exp_req = RPC; exp_del = RPC; n_del = 0; first_del = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, '0);
      if (ev_acc) begin
        vectors++; if (ev_addr !== exp_req) begin errors++; $display("FAIL seq_req_addr: got %h expected %h", ev_addr, exp_req); end
        exp_req += 64'd4;
      end
      if (ev_del) begin
        vectors++; if (ev_pc !== exp_del || ev_inst !== mem_word(exp_del)) begin
          errors++; $display("FAIL seq_deliver: got %h/%h expected %h/%h", ev_pc, ev_inst, exp_del, mem_word(exp_del));
        end
        if (first_del < 0) first_del = i;
        exp_del += 64'd4; n_del++;
      end
    end
    vectors++; if (first_del != 2) begin errors++; $display("FAIL seq_first_latency: got %0d expected 2", first_del); end
    vectors++; if (n_del < 20) begin errors++; $display("FAIL seq_throughput: got %0d expected >= 20", n_del); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_req, exp_del;
    int n_acc, n_del;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    exp_req = RPC; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0);
      if (ev_acc) begin
        vectors++; if (ev_addr !== exp_req) begin errors++; $display("FAIL bp_req_addr: got %h expected %h", ev_addr, exp_req); end
        exp_req += 64'd4; n_acc++;
      end
    end
    vectors++; if (n_acc != DEPTH) begin errors++; $display("FAIL bp_accept_count: got %0d expected %0d", n_acc, DEPTH); end
    vectors++; if (ev_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %b expected 0", ev_req); end
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== RPC) begin
      errors++; $display("FAIL bp_head: got %b/%h expected 1/%h", inst_valid, inst_pc, RPC);
    end
    inst_ready = 1'b1; exp_del = RPC; n_del = 0; n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0);
      if (ev_acc) begin
        vectors++; if (ev_addr !== exp_req) begin errors++; $display("FAIL bp_resume_addr: got %h expected %h", ev_addr, exp_req); end
        exp_req += 64'd4; n_acc++;
      end
      if (ev_del) begin
        vectors++; if (ev_pc !== exp_del || ev_inst !== mem_word(exp_del)) begin
          errors++; $display("FAIL bp_drain: got %h/%h expected %h/%h", ev_pc, ev_inst, exp_del, mem_word(exp_del));
        end
        exp_del += 64'd4; n_del++;
      end
    end
    vectors++; if (n_del < 6 || n_acc < 6) begin errors++; $display("FAIL bp_progress: got del %0d acc %0d expected >= 6 each", n_del, n_acc); end
  endtask

  task automatic test_redirect();
    int n_drop, n_iter;
    bit got;
    do_reset();
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    vectors++; if (mq.size() != 2) begin errors++; $display("FAIL rd_outstanding: got %0d expected 2", mq.size()); end
    cycle(1'b1, 64'h0000_0000_8000_1002);
    vectors++; if (ev_req !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect: got %b expected 0", ev_req); end
    n_drop = 0; n_iter = 0;
    while (mq.size() > 0 && n_iter < 10) begin
      cycle(1'b0, '0);
      n_iter++;
      if (ev_resp) n_drop++;
      vectors++; if (ev_req !== 1'b0 || ev_iv !== 1'b0) begin
        errors++; $display("FAIL rd_drain_quiet: got req %b inst_valid %b expected 0 0", ev_req, ev_iv);
      end
    end
    vectors++; if (n_drop != 2) begin errors++; $display("FAIL rd_dropped: got %0d expected 2", n_drop); end
    cycle(1'b0, '0);
    vectors++; if (ev_acc !== 1'b1 || ev_addr !== 64'h0000_0000_8000_1000) begin
      errors++; $display("FAIL rd_new_req: got %b/%h expected 1/0000000080001000", ev_acc, ev_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle(1'b0, '0);
      if (ev_del) begin
        got = 1'b1;
        vectors++; if (ev_pc !== 64'h0000_0000_8000_1000 || ev_inst !== mem_word(64'h0000_0000_8000_1000)) begin
          errors++; $display("FAIL rd_new_inst: got %h/%h expected 0000000080001000/%h", ev_pc, ev_inst, mem_word(64'h0000_0000_8000_1000));
        end
      end
    end
    if (!got) begin vectors++; errors++; $display("FAIL rd_timeout: got no delivery expected one within 12 cycles"); end
  endtask

  task automatic test_collision();
    logic [63:0] tgt;
    bit got;
    tgt = 64'h0000_0000_9000_0004;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b1, 64'h0000_0000_9000_0007);
    vectors++; if (ev_del !== 1'b1 || ev_pc !== RPC) begin
      errors++; $display("FAIL col_handshake: got %b/%h expected 1/%h", ev_del, ev_pc, RPC);
    end
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL col_fifo_empty: got %b expected 0", inst_valid); end
    cycle(1'b0, '0);
    vectors++; if (ev_acc !== 1'b1 || ev_addr !== tgt) begin
      errors++; $display("FAIL col_new_req: got %b/%h expected 1/%h", ev_acc, ev_addr, tgt);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b0, '0);
      if (ev_del) begin
        got = 1'b1;
        vectors++; if (ev_pc !== tgt || ev_inst !== mem_word(tgt)) begin
          errors++; $display("FAIL col_new_inst: got %h/%h expected %h/%h", ev_pc, ev_inst, tgt, mem_word(tgt));
        end
      end
    end
    if (!got) begin vectors++; errors++; $display("FAIL col_timeout: got no delivery expected one within 10 cycles"); end
  endtask

  task automatic test_req_stall();
    int n_del;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0);
      vectors++; if (ev_req !== 1'b1 || ev_addr !== RPC) begin
        errors++; $display("FAIL stall_hold: got %b/%h expected 1/%h", ev_req, ev_addr, RPC);
      end
    end
    imem_req_ready = 1'b1;
    cycle(1'b0, '0);
    vectors++; if (ev_acc !== 1'b1 || ev_addr !== RPC) begin
      errors++; $display("FAIL stall_accept: got %b/%h expected 1/%h", ev_acc, ev_addr, RPC);
    end
    imem_req_ready = 1'b0; n_del = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0);
      if (ev_del) begin
        n_del++;
        vectors++; if (ev_pc !== RPC || ev_inst !== mem_word(RPC)) begin
          errors++; $display("FAIL stall_inst: got %h/%h expected %h/%h", ev_pc, ev_inst, RPC, mem_word(RPC));
        end
      end
    end
    vectors++; if (n_del != 1) begin errors++; $display("FAIL stall_single: got %0d expected 1", n_del); end
  endtask

  task automatic test_reset_in_drain();
    bit got;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (6) cycle(1'b0, '0);
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && mq.size() < 2; i++) cycle(1'b0, '0);
    cycle(1'b1, 64'h0000_0000_8000_3000);
    cycle(1'b0, '0);
    vectors++; if (ev_req !== 1'b0) begin errors++; $display("FAIL rsd_draining: got %b expected 0", ev_req); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0) begin
      errors++; $display("FAIL rsd_async_clear: got %b %b %h %h expected 0 0 0 0", imem_req_valid, inst_valid, inst, inst_pc);
    end
    mq.delete();
    imem_resp_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cycle(1'b0, '0);
    vectors++; if (ev_acc !== 1'b1 || ev_addr !== RPC) begin
      errors++; $display("FAIL rsd_first_req: got %b/%h expected 1/%h", ev_acc, ev_addr, RPC);
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle(1'b0, '0);
      if (ev_del) begin
        got = 1'b1;
        vectors++; if (ev_pc !== RPC || ev_inst !== mem_word(RPC)) begin
          errors++; $display("FAIL rsd_first_inst: got %h/%h expected %h/%h", ev_pc, ev_inst, RPC, mem_word(RPC));
        end
      end
    end
    if (!got) begin vectors++; errors++; $display("FAIL rsd_timeout: got no delivery expected one within 12 cycles"); end
  endtask

  task automatic test_random();
    logic [63:0] exp_req, exp_del, rpc, pend_addr;
    bit redir, pend;
    int n_del;
    do_reset();
    lat_min = 1; lat_max = 4;
    exp_req = RPC; exp_del = RPC; n_del = 0; pend = 1'b0; pend_addr = '0;
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready = ($urandom_range(99) < 70);
      inst_ready     = ($urandom_range(99) < 75);
      redir          = ($urandom_range(99) < 3);
      if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      else                        rpc = 64'h0000_0000_8000_0000 + 64'($urandom_range(65535));
      cycle(redir, rpc);
      if (redir) begin
        vectors++; if (ev_req !== 1'b0) begin errors++; $display("FAIL rnd_req_in_redirect: got %b expected 0", ev_req); end
      end else if (pend) begin
        vectors++; if (ev_req !== 1'b1 || ev_addr !== pend_addr) begin
          errors++; $display("FAIL rnd_req_stable: got %b/%h expected 1/%h", ev_req, ev_addr, pend_addr);
        end
      end
      if (ev_acc) begin
        vectors++; if (ev_addr !== exp_req) begin errors++; $display("FAIL rnd_req_addr: got %h expected %h", ev_addr, exp_req); end
        exp_req += 64'd4;
      end
      if (ev_del) begin
        vectors++; if (ev_pc !== exp_del || ev_inst !== mem_word(exp_del)) begin
          errors++; $display("FAIL rnd_deliver: got %h/%h expected %h/%h", ev_pc, ev_inst, exp_del, mem_word(exp_del));
        end
        exp_del += 64'd4; n_del++;
      end
      if (redir) begin
        exp_req = rpc & ~64'h3;
        exp_del = rpc & ~64'h3;
      end
      vectors++; if (mq.size() > DEPTH) begin errors++; $display("FAIL rnd_inflight: got %0d expected <= %0d", mq.size(), DEPTH); end
      pend      = ev_req && !ev_acc;
      pend_addr = ev_addr;
    end
    vectors++; if (n_del < 500) begin errors++; $display("FAIL rnd_progress: got %0d expected >= 500", n_del); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_collision();
    test_req_stall();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
